// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers on a simple store bus,
// a one-byte holding register in front of a start/data/stop shifter.
module uart_mmio_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        MemWrite,
  output logic [31:0] HRDATA,
  output logic        tx,
  output logic        tx_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  shift_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic        tx_q;

  logic wr_data, wr_status, drain, accept, overflow, baud_done;
  logic unused_hwdata;

  assign wr_data       = MemWrite && (HADDR == BASE_ADDR);
  assign wr_status     = MemWrite && (HADDR == BASE_ADDR + 32'd4);
  assign drain         = (state_q == IDLE) && hold_full_q;
  // A write that lands while the holding byte is being drained is accepted.
  assign accept        = wr_data && (!hold_full_q || drain);
  assign overflow      = wr_data && hold_full_q && !drain;
  assign baud_done     = (baud_q == CLKS_PER_BIT - 16'd1);
  assign unused_hwdata = ^HWDATA[31:8];

  // NOTE: combinational next-state logic uses blocking '=' with a default on every
  // path (no latches); the clocked block below uses only non-blocking '<='.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_d       = ovf_q;
    if (drain) hold_full_d = 1'b0;
    if (accept) begin
      hold_d      = HWDATA[7:0];
      hold_full_d = 1'b1;
    end
    if (wr_status && HWDATA[2]) ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      shift_q     <= 8'h00;
      baud_q      <= 16'd0;
      bit_q       <= 3'd0;
      tx_q        <= 1'b1;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
      case (state_q)
        IDLE: begin
          baud_q <= 16'd0;
          bit_q  <= 3'd0;
          tx_q   <= 1'b1;
          if (hold_full_q) begin
            shift_q <= hold_q;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= 16'd0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= 16'd0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          // Leaving STOP always passes through exactly one IDLE cycle.
          if (baud_done) begin
            baud_q  <= 16'd0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    HRDATA = 32'b0;
    if (HADDR == BASE_ADDR + 32'd4)
      HRDATA = {29'b0, ovf_q, hold_full_q, state_q != IDLE};
    else if (HADDR == BASE_ADDR)
      HRDATA = {24'b0, hold_q};
  end

  assign tx      = tx_q;
  assign tx_busy = hold_full_q || (state_q != IDLE);

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Directed bench for uart_mmio_tx at 4 clocks per bit; a background monitor
// decodes frames off the tx line and the scenarios compare them with hand values.
module tb_uart_mmio_tx;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        MemWrite, tx, tx_busy;

  typedef struct {
    logic [7:0] data;
    int         gap;
    bit         ok;
  } frame_t;

  frame_t rx_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  uart_mmio_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(16'd4)) dut (
    .clk(clk), .rst(rst), .HADDR(HADDR), .HWDATA(HWDATA), .MemWrite(MemWrite),
    .HRDATA(HRDATA), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write takes effect on the next posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    HADDR = a; HWDATA = d; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    HADDR = a;
    #1;
    v = HRDATA;
  endtask

  task automatic wait_frames(input int n);
    int c = 0;
    while (rx_q.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("frames_arrive", rx_q.size(), n);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] exp);
    if (idx < rx_q.size()) begin
      check({tag, "_data"}, {24'b0, rx_q[idx].data}, {24'b0, exp});
      check({tag, "_shape"}, {31'b0, rx_q[idx].ok}, 32'd1);
    end else begin
      check({tag, "_present"}, rx_q.size(), idx + 1);
    end
  endtask

  // Frame monitor: 40 samples per frame (10 bits x 4 clks), aborts if busy drops.
  initial begin
    int         hi_cnt;
    logic [39:0] s;
    bit         aborted, ok;
    frame_t     f;
    hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (tx !== 1'b0 || tx_busy !== 1'b1) begin
        hi_cnt = (tx === 1'b1) ? hi_cnt + 1 : 0;
      end else begin
        s = '1;
        s[0] = tx;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          s[i] = tx;
          if (tx_busy !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
        end
        if (aborted) begin
          hi_cnt = 0;
        end else begin
          ok = (s[0] === 1'b0) && (s[36] === 1'b1);
          for (int k = 0; k < 10; k++)
            if (s[4*k +: 4] !== {4{s[4*k]}}) ok = 1'b0;
          for (int b = 0; b < 8; b++) f.data[b] = s[4*(b+1)];
          f.gap = hi_cnt;
          f.ok  = ok;
          rx_q.push_back(f);
          hi_cnt = 4;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; MemWrite = 1'b0; HADDR = '0; HWDATA = '0;
    idle(3);
    rst = 1'b0;

    // Reset state
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    rd(STAT, v); check("rst_status", v, 32'h0);
    rd(BASE, v); check("rst_hold", v, 32'h0);

    // Single byte A5
    wr(BASE, 32'h0000_00A5);
    rd(STAT, v); check("single_loaded", v, 32'h2);
    check("single_tx_idle", {31'b0, tx}, 32'd1);
    idle(1);
    rd(STAT, v); check("single_started", v, 32'h1);
    check("single_start_bit", {31'b0, tx}, 32'd0);
    idle(39);
    check("single_busy_in_stop", {31'b0, tx_busy}, 32'd1);
    idle(1);
    check("single_busy_fall", {31'b0, tx_busy}, 32'd0);
    wait_frames(1);
    check_frame("single", 0, 8'hA5);
    idle(5);
    rx_q.delete();

    // Back-to-back 55 then C3
    wr(BASE, 32'h55);
    idle(1);
    wr(BASE, 32'hC3);
    wait_frames(2);
    check_frame("b2b_f1", 0, 8'h55);
    check_frame("b2b_f2", 1, 8'hC3);
    if (rx_q.size() > 1) check("b2b_gap", rx_q[1].gap, 32'd5);
    idle(10);
    rd(STAT, v); check("b2b_status", v, 32'h0);
    rx_q.delete();

    // Overflow: 11, 22, 33 on consecutive edges
    wr(BASE, 32'h11);
    wr(BASE, 32'h22);
    wr(BASE, 32'h33);
    rd(STAT, v); check("ovf_status", v, 32'h7);
    rd(BASE, v); check("ovf_hold_kept", v, 32'h22);
    wait_frames(2);
    check_frame("ovf_f1", 0, 8'h11);
    check_frame("ovf_f2", 1, 8'h22);
    idle(60);
    check("ovf_no_third", rx_q.size(), 32'd2);
    rd(STAT, v); check("ovf_sticky", v, 32'h4);

    // ovf clear: bit2=0 keeps it, bit2=1 clears it
    wr(STAT, 32'hFB);
    rd(STAT, v); check("ovf_keep", v, 32'h4);
    wr(STAT, 32'h4);
    rd(STAT, v); check("ovf_cleared", v, 32'h0);
    rd(BASE + 32'd8, v); check("nodecode_p8", v, 32'h0);
    rd(BASE + 32'd1, v); check("nodecode_p1", v, 32'h0);
    rd(32'h0, v); check("nodecode_0", v, 32'h0);
    rx_q.delete();

    // Write on the drain edge
    wr(BASE, 32'h01);
    wr(BASE, 32'hF0);
    rd(STAT, v); check("sim_status", v, 32'h3);
    rd(BASE, v); check("sim_hold", v, 32'hF0);
    wait_frames(2);
    check_frame("sim_f1", 0, 8'h01);
    check_frame("sim_f2", 1, 8'hF0);
    idle(10);
    rd(STAT, v); check("sim_no_ovf", v, 32'h0);
    rx_q.delete();

    // Reset during DATA bit 3 of C3 (bit 3 = 0), with a write attempted under reset
    wr(BASE, 32'hC3);
    idle(17);
    check("rst_mid_bit3", {31'b0, tx}, 32'd0);
    rst = 1'b1; HADDR = BASE; HWDATA = 32'hAA; MemWrite = 1'b1;
    idle(1);
    rst = 1'b0; MemWrite = 1'b0;
    check("rst_mid_tx", {31'b0, tx}, 32'd1);
    check("rst_mid_busy", {31'b0, tx_busy}, 32'd0);
    rd(STAT, v); check("rst_mid_status", v, 32'h0);
    rd(BASE, v); check("rst_mid_hold", v, 32'h0);
    idle(50);
    check("rst_mid_no_frame", rx_q.size(), 32'd0);
    wr(BASE, 32'h0F);
    wait_frames(1);
    check_frame("rst_after", 0, 8'h0F);
    idle(10);
    check("rst_after_idle", {31'b0, tx_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
